div_tick_counter: RTL

DIV_TICK_COUNTER -- requirements
Module: div_tick_counter

---
 rtl/div_pkg.sv | 12 +
 rtl/div_tick_counter_if.sv | 24 ++
 rtl/edge_rise.sv | 19 +
 rtl/div_tick_counter.sv | 63 ++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divided-clock tick counter and its consumers.
package div_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = DIGIT_W'(9);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/div_tick_counter_if.sv
// Control inputs and BCD count outputs of the divided-clock tick counter.
interface div_tick_counter_if;
  import div_pkg::*;

  logic               q_in;
  logic               en;
  logic               clr;
  logic [DIGIT_W-1:0] ones;
  logic [DIGIT_W-1:0] tens;
  logic               tick;
  logic               wrap;
  logic               running;

  modport master (
    output q_in, en, clr,
    input  ones, tens, tick, wrap, running
  );

  modport slave (
    input  q_in, en, clr,
    output ones, tens, tick, wrap, running
  );

endinterface

// File: rtl/edge_rise.sv
// Rising-edge detector for a signal already synchronous to clk.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q_prev;

  // Reset to 1 so a level already high after reset is not taken as an edge.
  always_ff @(posedge clk) begin
    if (rst) q_prev <= 1'b1;
    else     q_prev <= d;
  end

  assign rise = d & ~q_prev;

endmodule

// File: rtl/div_tick_counter.sv
// Two-digit BCD counter of q_in rising edges, gated by an IDLE/RUN enable FSM.
module div_tick_counter
  import div_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  div_tick_counter_if.slave        bus
);

  state_t             state;
  logic [DIGIT_W-1:0] ones_q;
  logic [DIGIT_W-1:0] tens_q;
  logic               tick_q;
  logic               wrap_q;
  logic               rise;

  edge_rise u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.q_in),
    .rise (rise)
  );

  // The increment looks at the state before this edge's update, so an edge
  // arriving together with en going high is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ones_q <= '0;
      tens_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state  <= bus.en ? RUN : IDLE;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.clr) begin
        ones_q <= '0;
        tens_q <= '0;
      end else if (state == RUN && rise) begin
        tick_q <= 1'b1;
        if (ones_q == BCD_MAX) begin
          ones_q <= '0;
          if (tens_q == BCD_MAX) begin
            tens_q <= '0;
            wrap_q <= 1'b1;
          end else begin
            tens_q <= tens_q + DIGIT_W'(1);
          end
        end else begin
          ones_q <= ones_q + DIGIT_W'(1);
        end
      end
    end
  end

  assign bus.ones    = ones_q;
  assign bus.tens    = tens_q;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign bus.running = (state == RUN);

endmodule
